// File: rtl/poly_add_modq.sv
// Two-stage modular adder v = (a + b + c) mod Q with valid/ready handshake,
// per-polynomial last tagging and a sticky out-of-range input flag.
module poly_add_modq #(
  parameter int unsigned DATA_WID = 12,
  parameter int unsigned Q        = 3329,
  parameter int unsigned N        = 256
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [DATA_WID-1:0] in_a,
  input  logic [DATA_WID-1:0] in_b,
  input  logic [DATA_WID-1:0] in_c,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [DATA_WID-1:0] out_data,
  output logic                out_last,
  output logic                range_err
);

  localparam int unsigned SUM_W = DATA_WID + 1;
  localparam int unsigned IDX_W = (N > 1) ? $clog2(N) : 1;
  localparam logic [SUM_W-1:0] Q_EXT    = SUM_W'(Q);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(N - 1);

  // One conditional subtraction is enough because both operands are < Q.
  function automatic logic [DATA_WID-1:0] add_mod(input logic [DATA_WID-1:0] x,
                                                  input logic [DATA_WID-1:0] y);
    logic [SUM_W-1:0] sum;
    sum = {1'b0, x} + {1'b0, y};
    if (sum >= Q_EXT) sum = sum - Q_EXT;
    return sum[DATA_WID-1:0];
  endfunction

  logic                w_en;
  logic                w_accept;
  logic                w_in_err;

  logic [IDX_W-1:0]    r_idx;
  logic                r_range_err;
  logic                r_s1_valid;
  logic [DATA_WID-1:0] r_s1_sum;
  logic [DATA_WID-1:0] r_s1_c;
  logic                r_s1_last;
  logic                r_out_valid;
  logic [DATA_WID-1:0] r_out_data;
  logic                r_out_last;

  assign w_en     = !r_out_valid || out_ready;
  assign w_accept = in_valid && w_en;
  assign w_in_err = ({1'b0, in_a} >= Q_EXT) || ({1'b0, in_b} >= Q_EXT) ||
                    ({1'b0, in_c} >= Q_EXT);

  assign in_ready  = w_en;
  assign out_valid = r_out_valid;
  assign out_data  = r_out_data;
  assign out_last  = r_out_last;
  assign range_err = r_range_err;

  // Coefficient index and sticky range flag, advanced only on acceptance.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_idx       <= '0;
      r_range_err <= 1'b0;
    end else if (w_accept) begin
      r_idx <= (r_idx == IDX_LAST) ? '0 : r_idx + IDX_W'(1);
      if (w_in_err) r_range_err <= 1'b1;
    end
  end

  // Stage 1: a + b reduced, c and last tag carried alongside.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s1_valid <= 1'b0;
      r_s1_sum   <= '0;
      r_s1_c     <= '0;
      r_s1_last  <= 1'b0;
    end else if (w_en) begin
      r_s1_valid <= in_valid;
      if (in_valid) begin
        r_s1_sum  <= add_mod(in_a, in_b);
        r_s1_c    <= in_c;
        r_s1_last <= (r_idx == IDX_LAST);
      end
    end
  end

  // Stage 2: final reduction; an empty stage 1 slot leaves an empty output.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
      r_out_last  <= 1'b0;
    end else if (w_en) begin
      r_out_valid <= r_s1_valid;
      r_out_last  <= r_s1_valid && r_s1_last;
      if (r_s1_valid) r_out_data <= add_mod(r_s1_sum, r_s1_c);
    end
  end

endmodule

// File: tb/tb_poly_add_modq.sv
// Bench for poly_add_modq: directed corner cases plus a long random run,
// all outputs scored against a queue-based (a+b+c) mod Q reference.
module tb_poly_add_modq;

  localparam int unsigned DW = 12;
  localparam int unsigned QM = 3329;
  localparam int unsigned NP = 256;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          in_valid;
  logic          in_ready;
  logic [DW-1:0] in_a, in_b, in_c;
  logic          out_valid;
  logic          out_ready;
  logic [DW-1:0] out_data;
  logic          out_last;
  logic          range_err;

  poly_add_modq #(.DATA_WID(DW), .Q(QM), .N(NP)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_a      (in_a),
    .in_b      (in_b),
    .in_c      (in_c),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_last  (out_last),
    .range_err (range_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    int data;
    bit last;
    bit bad;
  } exp_t;

  exp_t          q[$];
  bit            m_err;
  int            m_cnt;
  int            n_acc;
  int            n_out;
  int            n_last;
  int            n_cmp;
  int            n_err;
  bit            prev_stall;
  logic [DW-1:0] prev_data;
  logic          prev_last;

  task automatic check(input string tag, input int got, input int exp);
    n_cmp++;
    if (got != exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic int rnd_coef();
    int r;
    r = int'($urandom_range(0, 9));
    if (r == 0) return int'(QM) - 1;
    if (r == 1) return 0;
    return int'($urandom_range(0, QM - 1));
  endfunction

  // Reference model and protocol checks, sampled mid-cycle on the falling edge.
  always @(negedge clk) begin
    exp_t e;
    check("range_err", int'(range_err), int'(m_err));
    if (!out_valid) begin
      check("last_without_valid", int'(out_last), 0);
      check("ready_when_empty", int'(in_ready), 1);
    end
    if (out_valid && !out_ready) check("ready_under_stall", int'(in_ready), 0);
    if (prev_stall) begin
      check("stall_valid", int'(out_valid), 1);
      check("stall_data", int'(out_data), int'(prev_data));
      check("stall_last", int'(out_last), int'(prev_last));
    end
    prev_stall = out_valid && !out_ready;
    prev_data  = out_data;
    prev_last  = out_last;
    if (out_valid && out_ready) begin
      n_out++;
      if (out_last) n_last++;
      if (q.size() == 0) begin
        check("unexpected_output", 1, 0);
      end else begin
        e = q.pop_front();
        if (!e.bad) check("out_data", int'(out_data), e.data);
        check("out_last", int'(out_last), int'(e.last));
      end
    end
    if (in_valid && in_ready) begin
      e.data = (int'(in_a) + int'(in_b) + int'(in_c)) % int'(QM);
      e.last = (m_cnt == int'(NP) - 1);
      e.bad  = (in_a >= DW'(QM)) || (in_b >= DW'(QM)) || (in_c >= DW'(QM));
      q.push_back(e);
      if (e.bad) m_err = 1'b1;
      m_cnt = (m_cnt + 1) % int'(NP);
      n_acc++;
    end
  end

  task automatic drive(input bit v, input int a, input int b, input int c, input bit rdy);
    @(posedge clk);
    #2;
    in_valid  = v;
    in_a      = DW'(a);
    in_b      = DW'(b);
    in_c      = DW'(c);
    out_ready = rdy;
  endtask

  // Reset pulse placed between clock edges so it acts purely asynchronously.
  task automatic do_reset();
    @(posedge clk);
    #2;
    rst_n      = 1'b0;
    in_valid   = 1'b0;
    out_ready  = 1'b1;
    q.delete();
    m_err      = 1'b0;
    m_cnt      = 0;
    prev_stall = 1'b0;
    #1;
    check("rst_out_valid", int'(out_valid), 0);
    check("rst_out_data", int'(out_data), 0);
    check("rst_out_last", int'(out_last), 0);
    check("rst_range_err", int'(range_err), 0);
    check("rst_in_ready", int'(in_ready), 1);
    #1;
    rst_n = 1'b1;
  endtask

  task automatic drain();
    for (int i = 0; i < 6; i++) drive(1'b0, 0, 0, 0, 1'b1);
    @(negedge clk);
    check("drain_queue_empty", q.size(), 0);
  endtask

  task automatic send_one(input int a, input int b, input int c, input int exp, input string tag);
    drive(1'b1, a, b, c, 1'b1);
    drive(1'b0, 0, 0, 0, 1'b1);
    @(negedge clk);
    check({tag, "_early"}, int'(out_valid), 0);
    @(negedge clk);
    check({tag, "_valid"}, int'(out_valid), 1);
    check({tag, "_data"}, int'(out_data), exp);
  endtask

  initial begin
    int n0, l0, cycles;
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    in_a = '0; in_b = '0; in_c = '0;
    m_err = 1'b0; m_cnt = 0; n_acc = 0; n_out = 0; n_last = 0;
    n_cmp = 0; n_err = 0; prev_stall = 1'b0; prev_data = '0; prev_last = 1'b0;

    // Modular corner cases with fixed latency.
    do_reset();
    send_one(3328, 1, 0, 0, "mod_wrap");
    send_one(1664, 1665, 3328, 3328, "mod_max");
    send_one(3328, 3328, 3328, 3326, "mod_all_max");
    drain();

    // Full-rate streaming over one polynomial plus one beat.
    do_reset();
    n0 = n_out; l0 = n_last;
    for (int i = 0; i < 259; i++) begin
      drive(i < 257, rnd_coef(), rnd_coef(), rnd_coef(), 1'b1);
      @(negedge clk);
      if (i >= 2) check("stream_no_bubble", int'(out_valid), 1);
    end
    drive(1'b0, 0, 0, 0, 1'b1);
    check("stream_out_count", n_out - n0, 257);
    check("stream_last_count", n_last - l0, 1);
    drain();

    // Backpressure: five stalled cycles while inputs keep coming.
    do_reset();
    for (int i = 0; i < 20; i++) begin
      drive(1'b1, rnd_coef(), rnd_coef(), rnd_coef(), !(i >= 6 && i < 11));
      @(negedge clk);
      if (i >= 6 && i < 11) begin
        check("bp_out_valid", int'(out_valid), 1);
        check("bp_in_ready", int'(in_ready), 0);
      end
    end
    drain();

    // Out-of-range input sets a sticky flag; later legal beats still correct.
    do_reset();
    drive(1'b1, 3329, 0, 0, 1'b1);
    for (int i = 0; i < 10; i++) begin
      drive(1'b1, rnd_coef(), rnd_coef(), rnd_coef(), 1'b1);
      @(negedge clk);
      check("err_sticky", int'(range_err), 1);
    end
    drain();
    send_one(5, 6, 7, 18, "after_err");
    check("err_still_set", int'(range_err), 1);
    drain();

    // Reset mid-polynomial, then a full polynomial from index 0.
    do_reset();
    for (int i = 0; i < 100; i++) drive(1'b1, rnd_coef(), rnd_coef(), rnd_coef(), 1'b1);
    do_reset();
    l0 = n_last;
    for (int i = 0; i < 256; i++) drive(1'b1, rnd_coef(), rnd_coef(), rnd_coef(), 1'b1);
    drain();
    check("midrst_last_count", n_last - l0, 1);

    // Long random run with random valid and ready.
    do_reset();
    n0 = n_acc; cycles = 0;
    while ((n_acc - n0) < 10000 && cycles < 60000) begin
      drive($urandom_range(0, 3) != 0, rnd_coef(), rnd_coef(), rnd_coef(),
            $urandom_range(0, 9) < 7);
      cycles++;
    end
    check("rand_beats_reached", int'((n_acc - n0) >= 10000), 1);
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/poly_add_modq.md
POLY_ADD_MODQ -- requirements
Module: poly_add_modq

Interface
REQ-001 SHALL have parameter DATA_WID, default 12, coefficient width in bits.
REQ-002 SHALL have parameter Q, default 3329, Kyber modulus.
REQ-003 SHALL have parameter N, default 256, coefficients per polynomial.
REQ-004 SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-005 SHALL have port rst_n, input, 1, reset; asynchronous, active-low.
REQ-006 SHALL have port in_valid, input, 1, the in_a/in_b/in_c triple is valid.
REQ-007 SHALL have port in_ready, output, 1, the block accepts the triple this cycle.
REQ-008 SHALL have ports in_a, in_b, in_c, input, DATA_WID each, coefficients of y, msg_poly and e_2.
REQ-009 SHALL have port out_valid, output, 1, out_data is valid.
REQ-010 SHALL have port out_ready, input, 1, the consumer accepts out_data.
REQ-011 SHALL have port out_data, output, DATA_WID, coefficient of v = (a + b + c) mod Q.
REQ-012 SHALL have port out_last, output, 1, out_data is coefficient N-1 of the polynomial.
REQ-013 SHALL have port range_err, output, 1, sticky flag: some accepted input was >= Q.

Function
REQ-014 SHALL accept an input beat in any cycle where in_valid && in_ready.
REQ-015 SHALL deliver an output beat in any cycle where out_valid && out_ready.
REQ-016 SHALL be a two-stage pipeline:
- S1 registers s1 = (a + b) mod Q, plus c.
- S2 registers out_data = (s1 + c) mod Q.
REQ-017 SHALL reduce each addition by forming the DATA_WID+1-bit sum (carry in the MSB) and subtracting Q exactly once when sum >= Q.
REQ-018 SHALL, for inputs all < Q, produce a result in [0, Q-1] equal to the exact modular sum.
REQ-019 SHALL use a global pipeline enable: en = !out_valid || out_ready, with in_ready = en combinationally.
REQ-020 SHALL advance S1 and S2 only when en is high, and hold all stage registers otherwise.
REQ-021 SHALL present the result on out_data exactly 2 cycles after acceptance when out_ready is held high.
REQ-022 SHALL sustain 1 beat/cycle throughput with no bubbles while in_valid and out_ready are held high.
REQ-023 SHALL, on a cycle with both an output handshake and an input acceptance, shift the pipeline without data loss or duplication.
REQ-024 SHALL propagate valid bits with the data: an S1 or S2 slot with no valid beat is empty and never produces an out_valid pulse.
REQ-025 SHALL keep out_data, out_last and out_valid stable while out_valid && !out_ready.
REQ-026 SHALL count accepted beats with an index counter idx in [0, N-1]:
- increments on each acceptance;
- wraps from N-1 to 0.
REQ-027 SHALL tag the beat accepted at idx == N-1 as last, and carry the tag through both stages to out_last.
REQ-028 SHALL drive out_last only while out_valid is high.
REQ-029 SHALL set range_err when an accepted beat has any of in_a, in_b or in_c >= Q.
REQ-030 SHALL hold range_err at 1 until reset.
REQ-031 SHALL leave out_data unspecified for a beat that sets range_err, while still emitting that beat and its last tag normally.
REQ-032 SHALL ignore in_a/in_b/in_c when no acceptance occurs.

Reset
REQ-033 SHALL, while rst_n is low, asynchronously force all of the following, regardless of clk:
- out_valid=0, out_last=0, out_data=0, range_err=0;
- idx=0;
- all stage valid bits and stage data registers to 0.
REQ-034 SHALL drive in_ready=1 during and immediately after reset, since the pipeline is empty.
REQ-035 SHALL, on reset mid-polynomial, discard in-flight beats and restart counting so that the next accepted beat is idx 0.

Verification
REQ-036 Bench SHALL cover modular results with out_ready=1:
- a=3328, b=1, c=0 -> out_data=0 two cycles after acceptance;
- a=1664, b=1665, c=3328 -> 3328;
- a=3328, b=3328, c=3328 -> 3326.
REQ-037 Bench SHALL cover streaming: 256 consecutive beats with in_valid=1 and out_ready=1 -> 256 outputs on consecutive cycles; out_last=1 only on the 256th; the 257th beat is treated as idx 0.
REQ-038 Bench SHALL cover backpressure: out_ready=0 for 5 cycles with out_valid=1 -> in_ready=0 and out_data/out_last stable throughout; on release, every beat appears exactly once and in order.
REQ-039 Bench SHALL cover range error: an accepted beat with in_a=3329 -> range_err=1 from the next cycle, held through 10 further valid beats; a subsequent legal beat 5+6+7 -> out_data=18.
REQ-040 Bench SHALL cover reset mid-frame: rst_n pulsed low after 100 accepted beats, with no clock edge during the pulse -> outputs immediately 0; after release, 256 beats yield out_last on beat 256 only.
REQ-041 Bench SHALL compare every output against a reference model (a+b+c) mod 3329 over at least 10000 random legal beats with random in_valid/out_ready.
